lycan_packet_router: RTL and testbench
======================================

Name: lycan_packet_router

Overview:
- Sits between the USB FIFO bridge and the peripheral array.
- RX direction: demultiplexes 32-bit host packets to one of `num_peripherals` (8) peripheral slots, selected by the packet address field.
- TX direction: round-robin arbitrates the peripherals' outgoing packets onto the single USB TX stream, stamping the source address into each packet.
- Also drops and counts packets addressed to disabled slots.

Parameters:
- NUM_PERIPH, default lycan_globals::num_peripherals (8); number of peripheral slots.
- PACKET_W, default lycan_globals::usb_packet_width (32); packet width in bits.
- ADDR_W, default lycan_globals::periph_address_width (3); width of the address field.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- usb_rx_data  in  PACKET_W  host-to-device packet.
- usb_rx_valid  in  1  usb_rx_data valid.
- usb_rx_ready  out  1  router accepts usb_rx_data this cycle.
- periph_rx_data  out  NUM_PERIPH x PACKET_W  packet to each slot; all slots driven from one shared hold register.
- periph_rx_valid  out  NUM_PERIPH  one-hot; packet pending for that slot.
- periph_rx_ready  in  NUM_PERIPH  slot accepts its packet.
- periph_tx_data  in  NUM_PERIPH x PACKET_W  device-to-host packet from each slot.
- periph_tx_valid  in  NUM_PERIPH  slot has a packet to send.
- periph_tx_ready  out  NUM_PERIPH  one-hot grant; slot packet consumed this cycle.
- usb_tx_data  out  PACKET_W  packet to the host.
- usb_tx_valid  out  1  usb_tx_data valid.
- usb_tx_ready  in  1  USB bridge accepts usb_tx_data.
- periph_enable  in  NUM_PERIPH  slot enable; sampled when a packet is accepted.
- rx_drop_count  out  16  saturating count of dropped RX packets.

Behaviour:
- Packet format: [31:29] peripheral address; [28:0] opaque to the router.
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge. Once asserted, valid and data stay stable until the transfer completes.

RX path:
- Single hold register (hold_valid, hold_data, hold_addr).
- usb_rx_ready = !hold_valid || periph_rx_ready[hold_addr] (combinational pass-through, full throughput).
- On accept with periph_enable[addr] = 1: load the hold register; the packet appears on periph_rx_valid[addr] the next cycle (1-cycle latency). Data is unmodified.
- On accept with periph_enable[addr] = 0: packet is consumed and discarded; hold is not loaded; rx_drop_count increments, saturating at 0xFFFF.
- Simultaneous delivery of the held packet and a new accept: the hold register is reloaded; no bubble.
- A held packet is delivered even if its slot is disabled after acceptance.

TX path:
- Output register: tx_valid, tx_data.
- Arbitration occurs when !tx_valid || usb_tx_ready.
  - Eligible set: periph_tx_valid & periph_enable.
  - Grant the first eligible index searching from (last_grant+1) mod NUM_PERIPH upward, with wrap.
  - periph_tx_ready[g] is asserted combinationally in that cycle only.
  - Load tx_data = {g[2:0], periph_tx_data[g][28:0]}; set last_grant <= g; tx_valid <= 1.
- If no slot is eligible while the register is freed: tx_valid <= 0 and last_grant is unchanged.
- Latency from grant to usb_tx_valid: 1 cycle. Sustained throughput: 1 packet/cycle when usb_tx_ready is held high.
- At most one periph_tx_ready bit is high in any cycle.

Reset:
- hold_valid = 0, tx_valid = 0, all periph_tx_ready = 0, rx_drop_count = 0.
- last_grant = NUM_PERIPH-1, so the first search starts at slot 0.
- usb_rx_ready = 1 in the first cycle after reset.
- Reset mid-operation discards held RX and TX packets without delivering them.

Decomposition:
- Additions to lycan_globals:
  - typedef usb_packet_t = logic [usb_packet_width-1:0]
  - typedef periph_addr_t = logic [periph_address_width-1:0]
  - localparams pkt_addr_msb = 31, pkt_addr_lsb = 29
- Sub-module lycan_rr_arbiter, parameterised N:
  - Inputs: req[N], advance.
  - Outputs: one-hot grant[N] and encoded grant index.
  - Holds the last_grant pointer internally.

Test Plan:
- Reset, all slots enabled, send 0x4000_0011 -> periph_rx_valid = 8'b0000_0100 next cycle with data 0x4000_0011; usb_rx_ready held 1 throughout.
- Back-to-back packets to slots 1, 1, 1 with periph_rx_ready[1] = 0 for 3 cycles -> first packet held; usb_rx_ready = 0 until slot 1 ready; all three delivered in order, none lost.
- periph_enable[5] = 0, send 0xA000_0000 x3 -> no periph_rx_valid; rx_drop_count = 3. Preload the counter path to 0xFFFF and send one more -> stays 0xFFFF.
- Slots 0, 3, 7 raise tx_valid continuously, usb_tx_ready = 1 -> grants cycle 0, 3, 7, 0, 3, 7; usb_tx_data[31:29] = 0, 3, 7 respectively, with the low 29 bits matching the source.
- usb_tx_ready = 0 for 4 cycles with slot 2 valid -> usb_tx_data stable and periph_tx_ready = 0 during the stall; exactly one grant after the stall clears.
- Assert rst while the hold register and TX register are full -> both valid outputs 0 next cycle; rx_drop_count = 0; the first subsequent TX grant goes to slot 0 if it is requesting.

Source files
------------

// File: rtl/lycan_packet_router_pkg.sv
// lycan_globals: system-wide sizing constants and shared types for the
// Lycan USB peripheral fabric.
//   num_peripherals      - number of peripheral slots behind the router
//   usb_packet_width     - width of one USB FIFO packet
//   periph_address_width - width of the packet address field
//   pkt_addr_msb/lsb     - position of the address field inside a packet
package lycan_globals;

    localparam int unsigned num_peripherals      = 8;
    localparam int unsigned usb_packet_width     = 32;
    localparam int unsigned periph_address_width = 3;

    typedef logic [usb_packet_width-1:0]     usb_packet_t;
    typedef logic [periph_address_width-1:0] periph_addr_t;

    localparam int unsigned pkt_addr_msb = 31;
    localparam int unsigned pkt_addr_lsb = 29;

endpackage

// File: rtl/lycan_rr_arbiter.sv
// lycan_rr_arbiter: round-robin arbiter with an internal last-grant pointer.
//   clk, rst    - clock, synchronous active-high reset
//   req         - request vector
//   advance     - arbitration allowed this cycle; grants are issued only here
//   grant       - one-hot grant (combinational)
//   grant_idx   - encoded index of the granted requester
//   grant_valid - a grant is issued this cycle
// The search starts one past the previous winner and wraps. After reset the
// pointer sits at N-1, so the first search starts at requester 0.
module lycan_rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] last_grant;
    int unsigned      cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        if (advance) begin
            for (int unsigned k = 1; k <= N; k++) begin
                cand = (32'(last_grant) + k) % N;
                if (!grant_valid && req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(cand);
                end
            end
            if (grant_valid) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(N - 1);
        end else if (grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/lycan_packet_router.sv
// lycan_packet_router: routes packets between the USB FIFO bridge and the
// peripheral slots.
//   clk, rst                        - clock, synchronous active-high reset
//   usb_rx_data/valid/ready         - host-to-device stream from the bridge
//   periph_rx_data/valid/ready      - per-slot delivery (one shared hold register)
//   periph_tx_data/valid/ready      - per-slot outgoing packets, one-hot grant
//   usb_tx_data/valid/ready         - device-to-host stream to the bridge
//   periph_enable                   - slot enables
//   rx_drop_count                   - saturating count of RX packets to disabled slots
// RX packets are demultiplexed by their address field; TX packets are
// round-robin arbitrated and stamped with the source slot address.
module lycan_packet_router
    import lycan_globals::*;
#(
    parameter int unsigned NUM_PERIPH = lycan_globals::num_peripherals,
    parameter int unsigned PACKET_W   = lycan_globals::usb_packet_width,
    parameter int unsigned ADDR_W     = lycan_globals::periph_address_width
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PACKET_W-1:0]              usb_rx_data,
    input  logic                             usb_rx_valid,
    output logic                             usb_rx_ready,
    output logic [NUM_PERIPH*PACKET_W-1:0]   periph_rx_data,
    output logic [NUM_PERIPH-1:0]            periph_rx_valid,
    input  logic [NUM_PERIPH-1:0]            periph_rx_ready,
    input  logic [NUM_PERIPH*PACKET_W-1:0]   periph_tx_data,
    input  logic [NUM_PERIPH-1:0]            periph_tx_valid,
    output logic [NUM_PERIPH-1:0]            periph_tx_ready,
    output logic [PACKET_W-1:0]              usb_tx_data,
    output logic                             usb_tx_valid,
    input  logic                             usb_tx_ready,
    input  logic [NUM_PERIPH-1:0]            periph_enable,
    output logic [15:0]                      rx_drop_count
);

    // ---------------- RX path ----------------
    logic                hold_valid;
    logic [PACKET_W-1:0] hold_data;
    logic [ADDR_W-1:0]   hold_addr;
    logic [ADDR_W-1:0]   rx_addr;
    logic                rx_accept;
    logic                rx_deliver;

    assign rx_addr      = usb_rx_data[PACKET_W-1 -: ADDR_W];
    assign usb_rx_ready = !hold_valid || periph_rx_ready[hold_addr];
    assign rx_accept    = usb_rx_valid && usb_rx_ready;
    assign rx_deliver   = hold_valid && periph_rx_ready[hold_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid    <= 1'b0;
            rx_drop_count <= '0;
        end else begin
            // A new accept takes priority over emptying, so delivery and
            // reload in the same cycle leave no bubble.
            if (rx_accept && periph_enable[rx_addr]) begin
                hold_valid <= 1'b1;
                hold_data  <= usb_rx_data;
                hold_addr  <= rx_addr;
            end else if (rx_deliver) begin
                hold_valid <= 1'b0;
            end
            if (rx_accept && !periph_enable[rx_addr] && rx_drop_count != '1) begin
                rx_drop_count <= rx_drop_count + 16'd1;
            end
        end
    end

    always_comb begin
        periph_rx_valid = '0;
        if (hold_valid) begin
            periph_rx_valid[hold_addr] = 1'b1;
        end
    end

    assign periph_rx_data = {NUM_PERIPH{hold_data}};

    // ---------------- TX path ----------------
    logic                tx_valid;
    logic [PACKET_W-1:0] tx_data;
    logic                tx_free;
    logic [ADDR_W-1:0]   arb_idx;
    logic                arb_valid;
    logic [PACKET_W-1:0] tx_sel;
    logic                unused_tx_hdr;

    assign tx_free = !tx_valid || usb_tx_ready;

    lycan_rr_arbiter #(
        .N     (NUM_PERIPH),
        .IDX_W (ADDR_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (periph_tx_valid & periph_enable),
        .advance     (tx_free && !rst),
        .grant       (periph_tx_ready),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        tx_sel = '0;
        for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
            if (periph_tx_ready[i]) begin
                tx_sel = periph_tx_data[i*PACKET_W +: PACKET_W];
            end
        end
    end

    // The slot's own address bits are replaced by the stamped source index.
    assign unused_tx_hdr = ^tx_sel[PACKET_W-1 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
        end else if (tx_free) begin
            tx_valid <= arb_valid;
            if (arb_valid) begin
                tx_data <= {arb_idx, tx_sel[PACKET_W-ADDR_W-1:0]};
            end
        end
    end

    assign usb_tx_valid = tx_valid;
    assign usb_tx_data  = tx_data;

endmodule

// File: tb/tb_lycan_packet_router.sv
module tb_lycan_packet_router;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  usb_rx_data;
    logic         usb_rx_valid;
    logic         usb_rx_ready;
    logic [255:0] periph_rx_data;
    logic [7:0]   periph_rx_valid;
    logic [7:0]   periph_rx_ready;
    logic [255:0] periph_tx_data;
    logic [7:0]   periph_tx_valid;
    logic [7:0]   periph_tx_ready;
    logic [31:0]  usb_tx_data;
    logic         usb_tx_valid;
    logic         usb_tx_ready;
    logic [7:0]   periph_enable;
    logic [15:0]  rx_drop_count;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    lycan_packet_router #(.NUM_PERIPH(8), .PACKET_W(32), .ADDR_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .usb_rx_data     (usb_rx_data),
        .usb_rx_valid    (usb_rx_valid),
        .usb_rx_ready    (usb_rx_ready),
        .periph_rx_data  (periph_rx_data),
        .periph_rx_valid (periph_rx_valid),
        .periph_rx_ready (periph_rx_ready),
        .periph_tx_data  (periph_tx_data),
        .periph_tx_valid (periph_tx_valid),
        .periph_tx_ready (periph_tx_ready),
        .usb_tx_data     (usb_tx_data),
        .usb_tx_valid    (usb_tx_valid),
        .usb_tx_ready    (usb_tx_ready),
        .periph_enable   (periph_enable),
        .rx_drop_count   (rx_drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packets in flight are kept as queues: at most one packet waiting for a
    // slot, at most one packet waiting for the USB bridge.
    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    logic [31:0] rx_log[$];
    int          grant_log[$];
    int          m_last  = 7;
    int          m_drops = 0;

    function automatic int pick(input logic [7:0] elig, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (elig[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        logic       exp_rr, free;
        logic [7:0] exp_rv, exp_gnt;
        int         a, g;
        a      = (rxq.size() != 0) ? int'(rxq[0][31:29]) : 0;
        exp_rr = (rxq.size() == 0) || periph_rx_ready[a];
        exp_rv = (rxq.size() != 0) ? (8'h01 << a) : 8'h00;
        free   = (txq.size() == 0) || usb_tx_ready;
        g      = (free && !rst) ? pick(periph_tx_valid & periph_enable, m_last) : -1;
        exp_gnt = (g >= 0) ? (8'h01 << g) : 8'h00;

        if (chk_en) begin
            chk("usb_rx_ready", {31'd0, usb_rx_ready}, {31'd0, exp_rr});
            chk("periph_rx_valid", {24'd0, periph_rx_valid}, {24'd0, exp_rv});
            if (rxq.size() != 0) chk("periph_rx_data", periph_rx_data[a*32 +: 32], rxq[0]);
            chk("periph_tx_ready", {24'd0, periph_tx_ready}, {24'd0, exp_gnt});
            chk("usb_tx_valid", {31'd0, usb_tx_valid}, {31'd0, txq.size() != 0});
            if (txq.size() != 0) chk("usb_tx_data", usb_tx_data, txq[0]);
            chk("rx_drop_count", {16'd0, rx_drop_count}, m_drops);
        end

        if (rst) begin
            rxq.delete();
            txq.delete();
            m_last  = 7;
            m_drops = 0;
        end else begin
            if (rxq.size() != 0 && periph_rx_ready[a]) begin
                rx_log.push_back(rxq.pop_front());
            end
            if (usb_rx_valid && exp_rr) begin
                if (periph_enable[usb_rx_data[31:29]]) rxq.push_back(usb_rx_data);
                else if (m_drops < 65535) m_drops++;
            end
            if (txq.size() != 0 && usb_tx_ready) void'(txq.pop_front());
            if (g >= 0) begin
                txq.push_back({3'(g), periph_tx_data[g*32 +: 29]});
                m_last = g;
                grant_log.push_back(g);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] txw[8];

    // Call at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [31:0] d);
        int n;
        usb_rx_valid = 1'b1;
        usb_rx_data  = d;
        n = 0;
        @(negedge clk);
        while (!usb_rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!usb_rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_accept_timeout: got ready=0 expected ready=1 within 50 cycles (data %h)", d);
        end
        @(posedge clk); #1;
        usb_rx_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[6];
        seq = '{0, 3, 7, 0, 3, 7};
        rst             = 1'b1;
        usb_rx_data     = '0;
        usb_rx_valid    = 1'b0;
        periph_rx_ready = 8'hFF;
        periph_tx_valid = 8'h00;
        usb_tx_ready    = 1'b1;
        periph_enable   = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            txw[i] = {3'(~i), 29'h1234560 + 29'(i)};
            periph_tx_data[i*32 +: 32] = txw[i];
        end
        step(2);
        chk_en = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_usb_rx_ready", {31'd0, usb_rx_ready}, 32'd1);
        chk("reset_drop_count", {16'd0, rx_drop_count}, 32'd0);
        @(posedge clk); #1;

        // Single packet to slot 2.
        send(32'h4000_0011);
        @(negedge clk);
        chk("t1_rx_valid", {24'd0, periph_rx_valid}, 32'h04);
        chk("t1_rx_data", periph_rx_data[2*32 +: 32], 32'h4000_0011);
        @(posedge clk); #1;

        // Three packets to slot 1 while it is not ready.
        rx_log.delete();
        periph_rx_ready[1] = 1'b0;
        fork
            begin
                send(32'h2000_0001);
                send(32'h2000_0002);
                send(32'h2000_0003);
            end
            begin
                step(4);
                periph_rx_ready[1] = 1'b1;
            end
        join
        step(3);
        chk("t2_delivered", rx_log.size(), 32'd3);
        if (rx_log.size() == 3) begin
            chk("t2_pkt0", rx_log[0], 32'h2000_0001);
            chk("t2_pkt1", rx_log[1], 32'h2000_0002);
            chk("t2_pkt2", rx_log[2], 32'h2000_0003);
        end

        // Drops to disabled slot 5, then saturation.
        periph_enable[5] = 1'b0;
        repeat (3) send(32'hA000_0000);
        @(negedge clk);
        chk("t3_drop3", {16'd0, rx_drop_count}, 32'd3);
        chk("t3_model_drop3", m_drops, 32'd3);
        @(posedge clk); #1;
        usb_rx_valid = 1'b1;
        usb_rx_data  = 32'hA000_0000;
        step(65540);
        usb_rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_drop_sat", {16'd0, rx_drop_count}, 32'h0000_FFFF);
        @(posedge clk); #1;
        periph_enable[5] = 1'b1;

        // Round-robin across slots 0, 3, 7.
        grant_log.delete();
        periph_tx_valid = 8'b1000_1001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4_grant", {24'd0, periph_tx_ready}, 32'h1 << seq[k]);
            if (k > 0) begin
                chk("t4_tx_addr", {29'd0, usb_tx_data[31:29]}, seq[k-1]);
                chk("t4_tx_low", {3'd0, usb_tx_data[28:0]}, {3'd0, txw[seq[k-1]][28:0]});
            end
        end
        @(posedge clk); #1;
        periph_tx_valid = 8'h00;
        chk("t4_model_grants", grant_log.size(), 32'd6);
        if (grant_log.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("t4_model_seq", grant_log[k], seq[k]);
        end
        step(3);

        // Stall with slot 2 requesting.
        usb_tx_ready    = 1'b0;
        periph_tx_valid = 8'h04;
        @(negedge clk);
        chk("t5_first_grant", {24'd0, periph_tx_ready}, 32'h04);
        @(posedge clk); #1;
        repeat (4) begin
            @(negedge clk);
            chk("t5_stall_grant", {24'd0, periph_tx_ready}, 32'h00);
            chk("t5_stall_data", usb_tx_data, 32'h4123_4562);
            chk("t5_stall_valid", {31'd0, usb_tx_valid}, 32'd1);
        end
        @(posedge clk); #1;
        usb_tx_ready = 1'b1;
        @(negedge clk);
        chk("t5_release_grant", {24'd0, periph_tx_ready}, 32'h04);
        @(posedge clk); #1;
        periph_tx_valid = 8'h00;
        @(negedge clk);
        chk("t5_no_second_grant", {24'd0, periph_tx_ready}, 32'h00);
        @(posedge clk); #1;
        step(2);

        // Reset with both registers full.
        periph_rx_ready[4] = 1'b0;
        send(32'h8000_0044);
        usb_tx_ready    = 1'b0;
        periph_tx_valid = 8'b0010_1001;
        @(negedge clk);
        chk("t6_pre_grant", {24'd0, periph_tx_ready}, 32'h08);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_pre_tx_valid", {31'd0, usb_tx_valid}, 32'd1);
        chk("t6_pre_rx_valid", {24'd0, periph_rx_valid}, 32'h10);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rx_valid", {24'd0, periph_rx_valid}, 32'h00);
        chk("t6_tx_valid", {31'd0, usb_tx_valid}, 32'd0);
        chk("t6_drop_count", {16'd0, rx_drop_count}, 32'd0);
        chk("t6_rx_ready", {31'd0, usb_rx_ready}, 32'd1);
        chk("t6_first_grant", {24'd0, periph_tx_ready}, 32'h01);
        @(posedge clk); #1;
        periph_tx_valid = 8'h00;
        usb_tx_ready    = 1'b1;
        periph_rx_ready = 8'hFF;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
